// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I width codes,
// the registered request record and the legality/alignment checks.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Width is carried in funct3[1:0]; the unsigned variants share the signed alignment rule.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory request/response bus between the LSU (master) and the data memory (slave).
interface lsu_mem_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data and
// load lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
  assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    be_o    = 4'hF;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_o = rdata_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'h0, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store initiator: one outstanding access, stalls the core until done.
// Optional MISALIGN_TRAP_EN traps misaligned H/W accesses instead of truncating low address bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        stall_o,
  lsu_mem_if.master   mem
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  lsu_state_e       state_q, state_d;
  lsu_req_t         req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             err_q, mis_q;

  logic        acc_illegal, acc_misalign, accept;
  logic        timeout_hit, timeout_fire, load_done;
  logic [3:0]  be_al;
  logic [31:0] wdata_al, ld_data;
  logic        unused_addr_hi;

  assign accept      = (state_q == IDLE) && req_valid_i;
  assign acc_illegal = !f3_legal(req_funct3_i);
`ifdef MISALIGN_TRAP_EN
  assign acc_misalign = is_misaligned(req_funct3_i, req_addr_i[1:0]);
`else
  assign acc_misalign = 1'b0;
`endif

  assign timeout_hit  = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
  assign timeout_fire = timeout_hit && (((state_q == REQ) && !mem.gnt) ||
                                        ((state_q == WAIT) && !mem.rvalid));
  assign load_done    = !req_q.we && (((state_q == REQ) && mem.gnt && mem.rvalid) ||
                                      ((state_q == WAIT) && mem.rvalid));
  assign unused_addr_hi = ^req_q.addr[31:ADDR_W+2];

  lsu_align u_align (
    .funct3_i (req_q.funct3),
    .offset_i (req_q.addr[1:0]),
    .wdata_i  (req_q.wdata),
    .rdata_i  (mem.rdata),
    .be_o     (be_al),
    .wdata_o  (wdata_al),
    .rdata_o  (ld_data)
  );

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every flop samples values from before the edge.
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid_i) state_d = (acc_illegal || acc_misalign) ? RESP : REQ;
      REQ: begin
        if (mem.gnt)          state_d = (req_q.we || mem.rvalid) ? RESP : WAIT;
        else if (timeout_hit) state_d = RESP;
      end
      WAIT:    if (mem.rvalid || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter restarts on every state change, so REQ and WAIT each get a full budget.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      cnt_q <= (state_q != state_d) ? '0 : cnt_q + 1'b1;
      if (accept) begin
        req_q   <= '{we: req_we_i, funct3: req_funct3_i, addr: req_addr_i, wdata: req_wdata_i};
        rdata_q <= '0;
        err_q   <= acc_illegal || acc_misalign;
        mis_q   <= acc_misalign;
      end
      if (load_done)    rdata_q <= ld_data;
      if (timeout_fire) err_q   <= 1'b1;
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
    err_o       = (state_q == RESP) && err_q;
    misalign_o  = (state_q == RESP) && mis_q;
    stall_o     = accept || (state_q == REQ) || (state_q == WAIT);
    mem.req     = (state_q == REQ);
    mem.we      = (state_q == REQ) && req_q.we;
    mem.addr    = (state_q == REQ) ? req_q.addr[ADDR_W+1:2] : '0;
    mem.be      = (state_q == REQ) ? be_al : '0;
    mem.wdata   = (state_q == REQ) ? wdata_al : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: store/load lane handling, wait states, timeout,
// illegal funct3, misalignment (both builds) and reset during an in-flight load.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W      = 10;
  localparam int TIMEOUT_CYC = 8;

  logic        clk_i = 1'b0;
  logic        reset_i, req_valid_i, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, rsp_valid_o, err_o, misalign_o, stall_o;
  logic [31:0] rsp_rdata_o;

  always #5 clk_i = ~clk_i;

  lsu_mem_if #(.ADDR_W(ADDR_W)) mem_bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .err_o        (err_o),
    .misalign_o   (misalign_o),
    .stall_o      (stall_o),
    .mem          (mem_bus)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int              r_lat;
  logic [31:0]     r_rdata, r_wdata;
  logic            r_err, r_mis, r_req_seen, r_we, r_stable, r_stall_ok, r_stall_resp, r_idle_after;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]      r_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one access and plays the memory: grant in REQ cycle gdly (-1 = never),
  // rvalid rdly cycles after the grant (0 = same cycle, -1 = never).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gdly, input int rdly,
                        input logic [31:0] rword);
    int   cyc, req_cyc, gnt_at;
    logic got;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i  = addr; req_wdata_i = wdata;
    r_lat = -1; r_rdata = 32'hxxxxxxxx; r_err = 1'bx; r_mis = 1'bx;
    r_req_seen = 1'b0; r_stable = 1'b1; r_stall_ok = 1'b1; r_stall_resp = 1'bx;
    r_we = 1'bx; r_addr = 'x; r_be = 'x; r_wdata = 'x;
    @(posedge clk_i);
    cyc = 0; req_cyc = 0; gnt_at = -1; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
      cyc++;
      #1;
      if (mem_bus.req) begin
        if (!stall_o) r_stall_ok = 1'b0;
        if (!r_req_seen) begin
          r_req_seen = 1'b1;
          r_we = mem_bus.we; r_addr = mem_bus.addr; r_be = mem_bus.be; r_wdata = mem_bus.wdata;
        end else if ({mem_bus.we, mem_bus.addr, mem_bus.be, mem_bus.wdata} !==
                     {r_we, r_addr, r_be, r_wdata}) begin
          r_stable = 1'b0;
        end
        if (req_cyc == gdly) begin
          mem_bus.gnt = 1'b1;
          gnt_at = cyc;
          if (!we && rdly == 0) begin
            mem_bus.rvalid = 1'b1; mem_bus.rdata = rword;
          end
        end
        req_cyc++;
      end else if (gnt_at >= 0 && rdly > 0 && cyc == gnt_at + rdly) begin
        mem_bus.rvalid = 1'b1; mem_bus.rdata = rword;
      end
      if (rsp_valid_o) begin
        got = 1'b1;
        r_lat = cyc; r_rdata = rsp_rdata_o; r_err = err_o; r_mis = misalign_o;
        r_stall_resp = stall_o;
      end
    end
    @(negedge clk_i);
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    #1;
    r_idle_after = req_ready_o && !rsp_valid_o;
  endtask

  initial begin
    reset_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_mem_req", mem_bus.req, 0);
    check("rst_stall", stall_o, 0);
    check("rst_err", err_o, 0);
    reset_i = 1'b1;

    // SW 0xDEADBEEF @0x10, zero-wait
    access(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
    check("sw_addr", r_addr, 32'd4);
    check("sw_be", r_be, 32'hF);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_we", r_we, 1);
    check("sw_lat", r_lat, 2);
    check("sw_err", r_err, 0);
    check("sw_rdata", r_rdata, 0);
    check("sw_stall_resp", r_stall_resp, 0);
    check("sw_idle_after", r_idle_after, 1);

    // mem[1] = 0x80FF7F01, byte/half loads at 0x6
    access(1'b0, F3_B, 32'h6, 32'h0, 0, 0, 32'h80FF7F01);
    check("lb_rdata", r_rdata, 32'hFFFFFFFF);
    check("lb_addr", r_addr, 32'd1);
    check("lb_be", r_be, 32'h4);
    check("lb_we", r_we, 0);
    check("lb_lat", r_lat, 2);
    access(1'b0, F3_BU, 32'h6, 32'h0, 0, 0, 32'h80FF7F01);
    check("lbu_rdata", r_rdata, 32'h000000FF);
    access(1'b0, F3_H, 32'h6, 32'h0, 0, 1, 32'h80FF7F01);
    check("lh_rdata", r_rdata, 32'hFFFF80FF);
    check("lh_lat", r_lat, 3);
    access(1'b0, F3_HU, 32'h6, 32'h0, 0, 2, 32'h80FF7F01);
    check("lhu_rdata", r_rdata, 32'h000080FF);
    check("lhu_lat", r_lat, 4);
    access(1'b0, F3_B, 32'h4, 32'h0, 0, 0, 32'h80FF7F01);
    check("lb0_rdata", r_rdata, 32'h00000001);

    // SB 0xA5 @0x3, grant delayed 3 cycles
    access(1'b1, F3_B, 32'h3, 32'h000000A5, 3, 0, 32'h0);
    check("sb_be", r_be, 32'h8);
    check("sb_wdata", r_wdata, 32'hA5A5A5A5);
    check("sb_addr", r_addr, 32'd0);
    check("sb_stable", r_stable, 1);
    check("sb_stall", r_stall_ok, 1);
    check("sb_lat", r_lat, 5);

    // SH @0x6 and a word load with a delayed zero-wait grant
    access(1'b1, F3_H, 32'h6, 32'h1234BEEF, 0, 0, 32'h0);
    check("sh_be", r_be, 32'hC);
    check("sh_wdata", r_wdata, 32'hBEEFBEEF);
    check("sh_addr", r_addr, 32'd1);
    access(1'b0, F3_W, 32'h8, 32'h0, 1, 0, 32'h12345678);
    check("lw_rdata", r_rdata, 32'h12345678);
    check("lw_lat", r_lat, 3);

    // rvalid never arrives: 8 WAIT cycles then error
    access(1'b0, F3_W, 32'h0, 32'h0, 0, -1, 32'h0);
    check("to_load_err", r_err, 1);
    check("to_load_rdata", r_rdata, 0);
    check("to_load_lat", r_lat, 10);
    check("to_load_idle", r_idle_after, 1);
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hFFFFFFFF;
    @(negedge clk_i);
    mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    #1;
    check("late_rvalid_rsp", rsp_valid_o, 0);
    check("late_rvalid_ready", req_ready_o, 1);

    // grant never arrives: timeout in REQ
    access(1'b1, F3_W, 32'h0, 32'h0, -1, 0, 32'h0);
    check("to_req_err", r_err, 1);
    check("to_req_lat", r_lat, 9);

    // LW @0x2
    access(1'b0, F3_W, 32'h2, 32'h0, 0, 0, 32'hCAFEF00D);
`ifdef MISALIGN_TRAP_EN
    check("mis_err", r_err, 1);
    check("mis_flag", r_mis, 1);
    check("mis_no_req", r_req_seen, 0);
    check("mis_rdata", r_rdata, 0);
    check("mis_lat", r_lat, 1);
`else
    check("mis_err", r_err, 0);
    check("mis_flag", r_mis, 0);
    check("mis_addr", r_addr, 32'd0);
    check("mis_be", r_be, 32'hF);
    check("mis_rdata", r_rdata, 32'hCAFEF00D);
    check("mis_lat", r_lat, 2);
`endif

    // illegal funct3
    access(1'b0, 3'b011, 32'h4, 32'h0, 0, 0, 32'h11111111);
    check("ill_err", r_err, 1);
    check("ill_no_req", r_req_seen, 0);
    check("ill_mis", r_mis, 0);
    check("ill_rdata", r_rdata, 0);
    check("ill_lat", r_lat, 1);

    // reset while waiting for read data
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = F3_W; req_addr_i = 32'h20;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1;
    check("rw_req", mem_bus.req, 1);
    mem_bus.gnt = 1'b1;
    @(negedge clk_i);
    mem_bus.gnt = 1'b0;
    #1;
    check("rw_wait_stall", stall_o, 1);
    check("rw_wait_noreq", mem_bus.req, 0);
    reset_i = 1'b0;
    @(negedge clk_i); #1;
    check("rw_rst_rsp", rsp_valid_o, 0);
    check("rw_rst_ready", req_ready_o, 1);
    check("rw_rst_stall", stall_o, 0);
    reset_i = 1'b1;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h55555555;
    repeat (3) begin
      @(negedge clk_i); #1;
      mem_bus.rvalid = 1'b0;
      check("rw_after_rsp", rsp_valid_o, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
